// File: rtl/cut_sweep_pkg.sv
// Shared types and sizing helpers for the CUT sweep controller.
package cut_sweep_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_WAIT   = 3'd2,
    S_SAMPLE = 3'd3,
    S_REPORT = 3'd4
  } sweep_state_t;

  // Each pass is a 0 vector followed by a 1 vector.
  function automatic int sweep_vectors(input int npass);
    return 2 * npass;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: lowest requesting index at or after the pointer, wrapping.
// The winner is latched on i_grant; i_advance moves the pointer just past it.
module rr_arbiter
  import cut_sweep_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            srst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_grant,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_pick,
  output logic            o_valid
);

  localparam int IW = idx_width(NREQ);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_win;
  logic [IW-1:0] w_hi_idx;
  logic [IW-1:0] w_lo_idx;
  logic [IW-1:0] w_pick_idx;
  logic          w_hi_found;

  // Descending scan leaves the lowest set index overall and the lowest one at/after the pointer.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo_idx = IW'(i);
        if (i >= int'(r_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IW'(i);
        end
      end
    end
    w_pick_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  assign o_valid = |i_req;
  assign o_pick  = o_valid ? (NREQ'(1) << w_pick_idx) : '0;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_ptr <= '0;
      r_win <= '0;
    end else begin
      if (i_grant) begin
        r_win <= w_pick_idx;
      end
      if (i_advance) begin
        r_ptr <= (r_win == IW'(NREQ - 1)) ? '0 : r_win + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cut_sweep_ctrl.sv
// Grants the buffer cell under test to one requester at a time, drives an
// alternating 0/1 sweep onto it and reports the saturating mismatch count.
module cut_sweep_ctrl
  import cut_sweep_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int NPASS  = 2,
  parameter int SETTLE = 2,
  parameter int ERRW   = 4
) (
  input  logic            CK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  output logic [NREQ-1:0] GNT,
  output logic            BUSY,
  output logic            DONE,
  output logic            PASS,
  output logic [ERRW-1:0] ERRCNT,
  output logic            CUT_A,
  input  logic            CUT_X
);

  localparam int V  = sweep_vectors(NPASS);
  localparam int VW = idx_width(V);
  localparam int CW = $clog2(SETTLE + 1);

  sweep_state_t    r_state;
  sweep_state_t    w_state_next;
  logic [NREQ-1:0] r_gnt;
  logic            r_cut_a;
  logic [ERRW-1:0] r_err;
  logic [VW-1:0]   r_idx;
  logic [CW-1:0]   r_cnt;

  logic            w_grant;
  logic            w_advance;
  logic            w_abort;
  logic            w_last_vec;
  logic [NREQ-1:0] w_pick;
  logic            w_arb_valid;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk      (CK),
    .srst     (RST),
    .i_req    (REQ),
    .i_grant  (w_grant),
    .i_advance(w_advance),
    .o_pick   (w_pick),
    .o_valid  (w_arb_valid)
  );

  // Only the granted requester can cancel a running sweep; others wait for IDLE.
  assign w_abort = ((r_state == S_DRIVE) || (r_state == S_WAIT) || (r_state == S_SAMPLE))
                   && !(|(REQ & r_gnt));
  assign w_last_vec = (r_idx == VW'(V - 1));

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_state_next = S_DRIVE;
          w_grant      = 1'b1;
        end
      end
      S_DRIVE:  w_state_next = S_WAIT;
      S_WAIT: begin
        if (r_cnt == CW'(1)) begin
          w_state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: w_state_next = w_last_vec ? S_REPORT : S_DRIVE;
      S_REPORT: begin
        w_state_next = S_IDLE;
        w_advance    = 1'b1;
      end
      default:  w_state_next = S_IDLE;
    endcase
    if (w_abort) begin
      w_state_next = S_IDLE;
      w_advance    = 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_gnt   <= '0;
      r_cut_a <= 1'b0;
      r_err   <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (w_abort) begin
      // ERRCNT deliberately keeps the partial count of the cancelled sweep.
      r_gnt   <= '0;
      r_cut_a <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt <= w_pick;
            r_err <= '0;
            r_idx <= '0;
          end
        end
        S_DRIVE: begin
          r_cut_a <= r_idx[0];
          r_cnt   <= CW'(SETTLE);
        end
        S_WAIT: r_cnt <= r_cnt - 1'b1;
        S_SAMPLE: begin
          if ((CUT_X != r_cut_a) && (r_err != '1)) begin
            r_err <= r_err + 1'b1;
          end
          if (!w_last_vec) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_REPORT: begin
          r_gnt   <= '0;
          r_cut_a <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign GNT    = r_gnt;
  assign BUSY   = (r_state != S_IDLE);
  assign DONE   = (r_state == S_REPORT);
  assign PASS   = DONE && (r_err == '0);
  assign ERRCNT = r_err;
  assign CUT_A  = r_cut_a;

endmodule

// File: tb/tb_cut_sweep_ctrl.sv
// Directed and randomized sweeps checked against a cycle-count / arithmetic
// model of grant order, sweep timing and mismatch counting.
module tb_cut_sweep_ctrl;

  localparam int NREQ   = 2;
  localparam int NPASS  = 2;
  localparam int SETTLE = 2;
  localparam int ERRW   = 2;
  localparam int NV     = 2 * NPASS;
  localparam int PER    = SETTLE + 2;
  localparam int ESAT   = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ERRW-1:0] errcnt;
  logic            cut_a;
  logic            cut_x;
  logic            cut_stuck0;
  logic            cut_flip;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;

  always #5 clk = ~clk;

  // Behavioural cell: a buffer, optionally stuck at 0 or with its output inverted.
  assign cut_x = cut_stuck0 ? 1'b0 : (cut_a ^ cut_flip);

  cut_sweep_ctrl #(
    .NREQ  (NREQ),
    .NPASS (NPASS),
    .SETTLE(SETTLE),
    .ERRW  (ERRW)
  ) dut (
    .CK    (clk),
    .RST   (rst),
    .REQ   (req),
    .GNT   (gnt),
    .BUSY  (busy),
    .DONE  (done),
    .PASS  (pass),
    .ERRCNT(errcnt),
    .CUT_A (cut_a),
    .CUT_X (cut_x)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req        = '0;
    cut_stuck0 = 1'b0;
    cut_flip   = 1'b0;
    step();
    step();
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", errcnt, 0);
    chk("rst_cuta", cut_a, 0);
    rst   = 1'b0;
    m_ptr = 0;
    step();
  endtask

  function automatic logic [NREQ-1:0] rr_expect(input logic [NREQ-1:0] r, input int ptr);
    for (int off = 0; off < NREQ; off++) begin
      if (r[(ptr + off) % NREQ]) return NREQ'(1) << ((ptr + off) % NREQ);
    end
    return '0;
  endfunction

  // Call while the DUT idles with req already set; returns in the IDLE cycle after DONE.
  // mode: 0 good cell, 1 stuck at 0, 2 inverted, 3 random per-vector faults.
  task automatic do_sweep(input logic [NREQ-1:0] exp_g, input int mode, input logic [NREQ-1:0] drop);
    int   f[NV];
    int   mism;
    int   exp_e;
    logic early;
    logic gnt_bad;
    cut_stuck0 = (mode == 1);
    mism = 0;
    for (int k = 0; k < NV; k++) begin
      f[k] = (mode == 2) ? 1 : (mode == 3) ? int'($urandom_range(0, 1)) : 0;
      if (mode == 1) mism += (k % 2);
      else mism += f[k];
    end
    exp_e = (mism > ESAT) ? ESAT : mism;
    step();
    chk("grant", gnt, exp_g);
    chk("busy", busy, 1);
    chk("err_clr", errcnt, 0);
    early   = 1'b0;
    gnt_bad = 1'b0;
    for (int c = 0; c < NV * PER; c++) begin
      cut_flip = f[c / PER][0];
      if (c % PER == SETTLE + 1) chk("cut_a_vec", cut_a, (c / PER) % 2);
      if (done) early = 1'b1;
      if (gnt !== exp_g) gnt_bad = 1'b1;
      step();
    end
    chk("early_done", early, 0);
    chk("gnt_held", gnt_bad, 0);
    chk("done", done, 1);
    chk("pass", pass, exp_e == 0);
    chk("errcnt", errcnt, exp_e);
    $display("sweep gnt=%b mode=%0d errcnt=%0d expected=%0d", gnt, mode, errcnt, exp_e);
    req = req & ~drop;
    step();
    chk("gnt_rel", gnt, 0);
    chk("cuta_rel", cut_a, 0);
    chk("done_pulse", done, 0);
    chk("idle", busy, 0);
    cut_flip   = 1'b0;
    cut_stuck0 = 1'b0;
    for (int i = 0; i < NREQ; i++) if (exp_g[i]) m_ptr = (i + 1) % NREQ;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] r;
    logic [NREQ-1:0] eg;

    do_reset();

    // Single requester: good cell, stuck-at-0 cell, inverted cell (saturates at 3).
    req = 2'b01;
    do_sweep(2'b01, 0, 2'b01);
    req = 2'b01;
    do_sweep(2'b01, 1, 2'b01);
    req = 2'b01;
    do_sweep(2'b01, 2, 2'b01);

    // Simultaneous requests from reset alternate through the pointer.
    do_reset();
    req = 2'b11;
    do_sweep(2'b01, 0, 2'b00);
    do_sweep(2'b10, 0, 2'b10);
    do_sweep(2'b01, 0, 2'b01);

    // Abort: requester 0 drops during its second WAIT cycle window.
    do_reset();
    cut_flip = 1'b1;
    req = 2'b11;
    step();
    chk("ab_grant", gnt, 2'b01);
    for (int c = 0; c < PER + 1; c++) step();
    req = 2'b10;
    step();
    chk("ab_gnt", gnt, 0);
    chk("ab_cuta", cut_a, 0);
    chk("ab_done", done, 0);
    chk("ab_busy", busy, 0);
    chk("ab_err_partial", errcnt, 1);
    $display("abort gnt=%b errcnt=%0d", gnt, errcnt);
    m_ptr = 1;
    do_sweep(2'b10, 0, 2'b10);

    // Reset in the middle of a sweep.
    do_reset();
    req = 2'b01;
    step();
    chk("rs_grant", gnt, 2'b01);
    for (int c = 0; c < 5; c++) step();
    rst = 1'b1;
    step();
    chk("rs_gnt", gnt, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", done, 0);
    chk("rs_cuta", cut_a, 0);
    chk("rs_err", errcnt, 0);
    $display("midsweep reset gnt=%b busy=%b", gnt, busy);
    rst   = 1'b0;
    m_ptr = 0;
    do_sweep(2'b01, 0, 2'b01);

    // Randomized requests and fault patterns against the model pointer.
    for (int it = 0; it < 10; it++) begin
      r   = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req = r;
      eg  = rr_expect(r, m_ptr);
      do_sweep(eg, int'($urandom_range(0, 3)), 2'b11);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
